// File: rtl/pipe_stage_skid.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_stage_skid
//  Brief    : Parametrised LEGv8 pipeline stage register with valid/ready
//             backpressure, a two-entry skid buffer, synchronous flush that
//             inserts a bubble, and a saturating stall counter.
//             All state advances on the falling edge of CLOCK.
//  Revision : 1.0 - initial release
// ============================================================================
module pipe_stage_skid #(
    parameter int DATA_W = 64,
    parameter int CTRL_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic              CLOCK,
    input  logic              RESET_N,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  stall_cnt
);

    // Occupancy encoding: EMPTY holds nothing, BUSY holds the main entry,
    // FULL holds main plus the skid entry.
    localparam logic [1:0] c_ST_EMPTY = 2'd0;
    localparam logic [1:0] c_ST_BUSY  = 2'd1;
    localparam logic [1:0] c_ST_FULL  = 2'd2;

    localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};

    logic [1:0]        r_state;
    logic [1:0]        w_next_state;
    logic              r_in_ready;
    logic              r_out_valid;
    logic [CTRL_W-1:0] r_main_ctrl;
    logic [DATA_W-1:0] r_main_data;
    logic [CTRL_W-1:0] r_skid_ctrl;
    logic [DATA_W-1:0] r_skid_data;
    logic [CNT_W-1:0]  r_stall_cnt;
    logic              w_in_fire;
    logic              w_out_fire;

    // Handshakes use only registered ready/valid, so no combinational
    // path exists from out_ready back to in_ready.
    assign w_in_fire  = in_valid & r_in_ready;
    assign w_out_fire = r_out_valid & out_ready;

    // Next occupancy; flush always empties the stage.
    always_comb begin
        w_next_state = r_state;
        if (flush) begin
            w_next_state = c_ST_EMPTY;
        end else begin
            case (r_state)
                c_ST_EMPTY: begin
                    if (w_in_fire) w_next_state = c_ST_BUSY;
                end
                c_ST_BUSY: begin
                    if (w_in_fire && !w_out_fire)      w_next_state = c_ST_FULL;
                    else if (!w_in_fire && w_out_fire) w_next_state = c_ST_EMPTY;
                end
                c_ST_FULL: begin
                    if (w_out_fire) w_next_state = c_ST_BUSY;
                end
                default: w_next_state = c_ST_EMPTY;
            endcase
        end
    end

    // State plus registered handshake flags derived from the next state.
    always_ff @(negedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state     <= c_ST_EMPTY;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            r_state     <= w_next_state;
            r_in_ready  <= (w_next_state != c_ST_FULL);
            r_out_valid <= (w_next_state != c_ST_EMPTY);
        end
    end

    // Main/skid payload registers; control is zeroed whenever a slot empties
    // so squashed or drained entries carry no side effects.
    always_ff @(negedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_main_ctrl <= '0;
            r_main_data <= '0;
            r_skid_ctrl <= '0;
            r_skid_data <= '0;
        end else if (flush) begin
            r_main_ctrl <= '0;
            r_skid_ctrl <= '0;
        end else begin
            case (r_state)
                c_ST_EMPTY: begin
                    if (w_in_fire) begin
                        r_main_ctrl <= in_ctrl;
                        r_main_data <= in_data;
                    end
                end
                c_ST_BUSY: begin
                    if (w_in_fire && w_out_fire) begin
                        r_main_ctrl <= in_ctrl;
                        r_main_data <= in_data;
                    end else if (w_in_fire) begin
                        r_skid_ctrl <= in_ctrl;
                        r_skid_data <= in_data;
                    end else if (w_out_fire) begin
                        r_main_ctrl <= '0;
                    end
                end
                c_ST_FULL: begin
                    if (w_out_fire) begin
                        r_main_ctrl <= r_skid_ctrl;
                        r_main_data <= r_skid_data;
                        r_skid_ctrl <= '0;
                    end
                end
                default: begin
                    r_main_ctrl <= '0;
                    r_skid_ctrl <= '0;
                end
            endcase
        end
    end

    // Saturating count of edges where a valid entry is held back downstream.
    always_ff @(negedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_stall_cnt <= '0;
        end else if (r_out_valid && !out_ready && !flush && (r_stall_cnt != c_CNT_MAX)) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_ctrl  = r_main_ctrl;
    assign out_data  = r_main_data;
    assign stall_cnt = r_stall_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_skid.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pipe_stage_skid
//  Brief    : Directed, table-driven self-checking bench for pipe_stage_skid.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_stage_skid;

    localparam int DATA_W = 64;
    localparam int CTRL_W = 8;
    localparam int CNT_W  = 4;

    logic              CLOCK;
    logic              RESET_N;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [CTRL_W-1:0] in_ctrl;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [CTRL_W-1:0] out_ctrl;
    logic [DATA_W-1:0] out_data;
    logic [CNT_W-1:0]  stall_cnt;

    int total;
    int bad;

    pipe_stage_skid #(
        .DATA_W (DATA_W),
        .CTRL_W (CTRL_W),
        .CNT_W  (CNT_W)
    ) u_dut (
        .CLOCK     (CLOCK),
        .RESET_N   (RESET_N),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_ctrl   (in_ctrl),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ctrl  (out_ctrl),
        .out_data  (out_data),
        .stall_cnt (stall_cnt)
    );

    initial CLOCK = 1'b1;
    always #5 CLOCK = ~CLOCK;

    typedef struct {
        logic        fl;
        logic        iv;
        logic [7:0]  ic;
        logic [63:0] id;
        logic        ordy;
        logic        e_ov;
        logic        e_ir;
        logic [7:0]  e_oc;
        logic [63:0] e_od;
        logic [3:0]  e_sc;
    } vec_t;

    vec_t vecs [20];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic fl, input logic iv, input logic [7:0] ic,
                         input logic [63:0] id, input logic ordy);
        flush     = fl;
        in_valid  = iv;
        in_ctrl   = ic;
        in_data   = id;
        out_ready = ordy;
    endtask

    // Advance one active (falling) edge, then settle before sampling.
    task automatic tick();
        @(negedge CLOCK);
        #1;
    endtask

    task automatic do_reset();
        RESET_N = 1'b0;
        drive(1'b0, 1'b0, 8'h00, 64'h0, 1'b0);
        tick();
        tick();
        RESET_N = 1'b1;
        #1;
    endtask

    initial begin
        total   = 0;
        bad     = 0;
        RESET_N = 1'b1;
        drive(1'b0, 1'b0, 8'h00, 64'h0, 1'b0);

        //              fl iv  ic     id     ordy ov ir  oc     od     sc
        vecs[0]  = '{1'b0,1'b1,8'h81,64'h10,1'b1,1'b0,1'b1,8'h00,64'h00,4'd0}; // ignored, ready rises
        vecs[1]  = '{1'b0,1'b1,8'h81,64'h10,1'b1,1'b1,1'b1,8'h81,64'h10,4'd0};
        vecs[2]  = '{1'b0,1'b1,8'h81,64'h11,1'b1,1'b1,1'b1,8'h81,64'h11,4'd0};
        vecs[3]  = '{1'b0,1'b1,8'h81,64'h12,1'b1,1'b1,1'b1,8'h81,64'h12,4'd0};
        vecs[4]  = '{1'b0,1'b0,8'h00,64'h00,1'b1,1'b0,1'b1,8'h00,64'h12,4'd0};
        vecs[5]  = '{1'b0,1'b1,8'h05,64'h20,1'b0,1'b1,1'b1,8'h05,64'h20,4'd0}; // BUSY 0x20
        vecs[6]  = '{1'b0,1'b1,8'h06,64'h21,1'b0,1'b1,1'b0,8'h05,64'h20,4'd1}; // FULL
        vecs[7]  = '{1'b0,1'b1,8'h07,64'h22,1'b0,1'b1,1'b0,8'h05,64'h20,4'd2}; // 0x22 held
        vecs[8]  = '{1'b0,1'b1,8'h07,64'h22,1'b1,1'b1,1'b1,8'h06,64'h21,4'd2}; // skid -> main
        vecs[9]  = '{1'b0,1'b1,8'h07,64'h22,1'b1,1'b1,1'b1,8'h07,64'h22,4'd2};
        vecs[10] = '{1'b0,1'b0,8'h00,64'h00,1'b1,1'b0,1'b1,8'h00,64'h22,4'd2};
        vecs[11] = '{1'b0,1'b1,8'h09,64'h30,1'b0,1'b1,1'b1,8'h09,64'h30,4'd2};
        vecs[12] = '{1'b0,1'b1,8'h0a,64'h31,1'b0,1'b1,1'b0,8'h09,64'h30,4'd3}; // FULL 30/31
        vecs[13] = '{1'b1,1'b1,8'h0b,64'h32,1'b0,1'b0,1'b1,8'h00,64'h30,4'd3}; // flush, no count
        vecs[14] = '{1'b0,1'b0,8'h00,64'h00,1'b1,1'b0,1'b1,8'h00,64'h30,4'd3}; // 31 gone
        vecs[15] = '{1'b0,1'b1,8'hff,64'h40,1'b1,1'b1,1'b1,8'hff,64'h40,4'd3};
        vecs[16] = '{1'b0,1'b0,8'h00,64'h00,1'b1,1'b0,1'b1,8'h00,64'h40,4'd3}; // bubble
        vecs[17] = '{1'b0,1'b0,8'h3c,64'hx, 1'b1,1'b0,1'b1,8'h00,64'h40,4'd3}; // X idle payload
        vecs[18] = '{1'b0,1'b1,8'h11,64'h50,1'b1,1'b1,1'b1,8'h11,64'h50,4'd3};
        vecs[19] = '{1'b1,1'b1,8'h12,64'h51,1'b1,1'b0,1'b1,8'h00,64'h50,4'd3}; // flush + fires

        // Reset state, checked before any clock edge after release.
        do_reset();
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_in_ready",  {63'd0, in_ready},  64'd0);
        chk("rst_out_ctrl",  {56'd0, out_ctrl},  64'd0);
        chk("rst_out_data",  out_data,           64'd0);
        chk("rst_stall_cnt", {60'd0, stall_cnt}, 64'd0);

        for (int i = 0; i < 20; i++) begin
            drive(vecs[i].fl, vecs[i].iv, vecs[i].ic, vecs[i].id, vecs[i].ordy);
            tick();
            chk($sformatf("v%0d_out_valid", i), {63'd0, out_valid}, {63'd0, vecs[i].e_ov});
            chk($sformatf("v%0d_in_ready", i),  {63'd0, in_ready},  {63'd0, vecs[i].e_ir});
            chk($sformatf("v%0d_out_ctrl", i),  {56'd0, out_ctrl},  {56'd0, vecs[i].e_oc});
            chk($sformatf("v%0d_out_data", i),  out_data,           vecs[i].e_od);
            chk($sformatf("v%0d_stall_cnt", i), {60'd0, stall_cnt}, {60'd0, vecs[i].e_sc});
        end

        // Stall counter saturation on a fresh reset.
        do_reset();
        drive(1'b0, 1'b0, 8'h00, 64'h0, 1'b0);
        tick();
        drive(1'b0, 1'b1, 8'h21, 64'h60, 1'b0);
        tick();
        chk("sat_fill_valid", {63'd0, out_valid}, 64'd1);
        drive(1'b0, 1'b0, 8'h00, 64'h0, 1'b0);
        for (int k = 1; k <= 20; k++) begin
            tick();
            chk($sformatf("sat_cnt_%0d", k), {60'd0, stall_cnt}, (k > 15) ? 64'd15 : 64'(k));
        end

        // Fill the skid slot, then assert reset between edges.
        drive(1'b0, 1'b1, 8'h22, 64'h61, 1'b0);
        tick();
        chk("full_in_ready", {63'd0, in_ready}, 64'd0);
        chk("full_out_data", out_data, 64'h60);
        #2;
        RESET_N = 1'b0;
        #1;
        chk("arst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("arst_in_ready",  {63'd0, in_ready},  64'd0);
        chk("arst_stall_cnt", {60'd0, stall_cnt}, 64'd0);
        chk("arst_out_ctrl",  {56'd0, out_ctrl},  64'd0);
        chk("arst_out_data",  out_data,           64'd0);

        // After release the old skid entry must not reappear.
        RESET_N = 1'b1;
        drive(1'b0, 1'b0, 8'h00, 64'h0, 1'b1);
        tick();
        tick();
        chk("post_rst_valid", {63'd0, out_valid}, 64'd0);
        chk("post_rst_ready", {63'd0, in_ready},  64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pipe_stage_skid.md
Name: pipe_stage_skid

Overview:
- Parametrised pipeline stage register for the LEGv8 pipeline. It is the successor to the fixed per-stage latches and replaces IFID/IDEX/EXMEM/MEMWB-style blocks.
- Adds valid/ready backpressure, a 2-entry skid buffer so stalls do not create a combinational ready path, and synchronous flush that inserts a bubble.
- Control fields (regwrite, memwrite, branch bits) are zeroed on every bubble so squashed instructions have no side effects.

Parameters:
DATA_W, 64, width of the datapath payload (PC, operands, immediates packed by the instantiator)
CTRL_W, 8, width of the control payload; forced to zero whenever the stage holds a bubble
CNT_W, 16, width of the saturating stall counter

Ports:
CLOCK  input  1  stage clock; all state updates on the falling edge
RESET_N  input  1  asynchronous active-low reset
flush  input  1  synchronous squash of all held entries (branch mispredict)
in_valid  input  1  upstream presents an entry
in_ready  output  1  stage can accept; registered
in_ctrl  input  CTRL_W  upstream control payload
in_data  input  DATA_W  upstream data payload
out_valid  output  1  stage holds a valid entry; registered
out_ready  input  1  downstream accepts
out_ctrl  output  CTRL_W  control payload; zero when out_valid=0
out_data  output  DATA_W  data payload; holds its last value when out_valid=0
stall_cnt  output  CNT_W  count of stalled edges

Behaviour:
- Transfer definitions, sampled at the falling edge of CLOCK:
  - in_fire = in_valid & in_ready
  - out_fire = out_valid & out_ready
- Storage:
  - main register (drives out_*)
  - skid register (ctrl+data)
  - state in {EMPTY, BUSY, FULL}
- Derived outputs:
  - out_valid = (state != EMPTY)
  - in_ready (registered) = (next state != FULL)
- Transitions when flush=0:
  - EMPTY: in_fire -> BUSY, main<=in. Otherwise stay.
  - BUSY, in_fire & out_fire: stay BUSY, main<=in.
  - BUSY, in_fire & !out_fire: -> FULL, skid<=in.
  - BUSY, !in_fire & out_fire: -> EMPTY, main ctrl<=0.
  - BUSY, neither: hold.
  - FULL: in_ready=0, so there is no in_fire. out_fire -> BUSY, main<=skid, skid ctrl<=0. Otherwise hold.
- Flush has priority over everything:
  - Next state EMPTY; main and skid ctrl cleared to 0; in_ready<=1.
  - Any in_fire or out_fire on the same edge: the downstream transfer of the old entry still counts as consumed. The incoming entry is discarded.
- Latency: 1 falling edge from in_fire to out_valid when EMPTY or BUSY-with-out_fire. Throughput: 1 entry per cycle with out_ready held high.
- Ordering: strictly FIFO; the skid entry always exits after the main entry.
- stall_cnt:
  - Increments on each falling edge with out_valid & !out_ready & !flush.
  - Saturates at 2^CNT_W-1 (no wrap).
  - Cleared only by reset.
- Reset (RESET_N=0, asynchronous, immediate):
  - state=EMPTY, out_valid=0, in_ready=0, out_ctrl=0, out_data=0, skid=0, stall_cnt=0.
  - On the first falling edge after deassertion, in_ready becomes 1. in_valid is ignored until then.
  - Reset asserted mid-transfer discards both entries; no partial update.
- Payload-only edges (no fire) leave out_data unchanged. X on in_data while in_valid=0 never propagates.

Test Plan:
- Reset then stream: RESET_N low, release; in_valid=1 with data 0x10,0x11,0x12, ctrl=0x81, out_ready=1.
  -> in_ready=1 after 1st edge; out_data 0x10,0x11,0x12 on consecutive edges, 1-edge latency; out_ctrl=0x81 while valid.
- Backpressure/skid: BUSY holding 0x20; drop out_ready; push 0x21.
  -> state FULL, in_ready=0; 0x22 held upstream.
  -> Raise out_ready: outputs 0x20, 0x21, 0x22 in order, no loss or duplication.
- Flush in FULL: FULL holding 0x30/0x31; flush=1 with in_valid=1, data 0x32.
  -> Next edge out_valid=0, out_ctrl=0x00, in_ready=1; 0x30, 0x31 and 0x32 never appear.
- Bubble control zeroing: single entry ctrl=0xFF, data 0x40 drained, then in_valid=0.
  -> out_valid=0, out_ctrl=0x00, out_data stays 0x40.
- Stall counter saturation: CNT_W=4; out_valid=1, out_ready=0 for 20 edges.
  -> stall_cnt counts 1..15 and stays 15; flush edge does not increment.
- Async reset mid-operation: assert RESET_N low between edges while FULL.
  -> Immediately out_valid=0, in_ready=0, stall_cnt=0, without waiting for a clock edge.
